// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce.
// Drives columns one-hot, synchronizes the row lines and emits one {row, col}
// one-hot pair per debounced press. Define KEYPAD_REPEAT_EN to add auto-repeat
// pulses while a key stays held.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 4800,
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned REPEAT_CYCLES   = 24000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_rows,
  output logic [3:0] key_cols,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CntMax = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t ScanLast = cnt_t'(SCAN_DIV - 1);
  localparam cnt_t DebLast  = cnt_t'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } state_e;

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [3:0] rows_m, rows_s;
  logic [3:0] cols_q, cols_d;
  logic [3:0] cand_row_q, cand_row_d;
  logic [3:0] cand_col_q, cand_col_d;
  logic [3:0] key_rows_q, key_rows_d;
  logic [3:0] key_cols_q, key_cols_d;
  logic       key_valid_q, key_held_q;
  logic       valid_d, held_d;
  logic       rep_pulse;
  logic [3:0] cols_next;
  logic       rows_onehot;
  logic       row_hit;

  assign cols_next   = {cols_q[2:0], cols_q[3]};
  assign rows_onehot = (rows_s != 4'd0) && ((rows_s & (rows_s - 4'd1)) == 4'd0);
  // Only the accepted row is watched once held, so a second key is ignored.
  assign row_hit     = |(rows_s & cand_row_q);

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows_m <= 4'd0;
      rows_s <= 4'd0;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
    end
  end

  // Next-state, counter and output computation for the scan/debounce FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cols_d     = cols_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    key_rows_d = key_rows_q;
    key_cols_d = key_cols_q;
    valid_d    = 1'b0;
    unique case (state_q)
      StScan: begin
        if (cnt_q == ScanLast) begin
          cnt_d = '0;
          if (rows_onehot) begin
            // Freeze the column on a single-row hit and start debouncing it.
            cand_row_d = rows_s;
            cand_col_d = cols_q;
            state_d    = StDebounce;
          end else begin
            cols_d = cols_next;
          end
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StDebounce: begin
        if (rows_s == cand_row_q) begin
          if (cnt_q == DebLast) begin
            state_d    = StHeld;
            cnt_d      = '0;
            key_rows_d = cand_row_q;
            key_cols_d = cand_col_q;
            valid_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end else begin
          state_d = StScan;
          cnt_d   = '0;
          cols_d  = cols_next;
        end
      end
      StHeld: begin
        if (!row_hit) begin
          state_d = StRelease;
          cnt_d   = '0;
        end
      end
      StRelease: begin
        if (row_hit) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StScan;
          cnt_d   = '0;
          cols_d  = cols_next;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = StScan;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == StHeld) || (state_d == StRelease);
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_CYCLES);

  typedef logic [RepW-1:0] rep_t;

  localparam rep_t RepLast = rep_t'(REPEAT_CYCLES - 1);

  rep_t rep_q, rep_d;
  logic hold_now, hold_next;

  assign hold_now  = (state_q == StHeld) || (state_q == StRelease);
  assign hold_next = held_d;

  // Repeat timer runs across HELD/RELEASE bounces and clears on leaving to SCAN.
  always_comb begin
    rep_d     = '0;
    rep_pulse = 1'b0;
    if (hold_now && hold_next) begin
      if (rep_q == RepLast) begin
        rep_pulse = 1'b1;
      end else begin
        rep_d = rep_q + rep_t'(1);
      end
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  // Repeat period is meaningless without the repeat feature.
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
  assign rep_pulse     = 1'b0;
`endif

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StScan;
      cnt_q       <= '0;
      cols_q      <= 4'b0001;
      cand_row_q  <= 4'd0;
      cand_col_q  <= 4'd0;
      key_rows_q  <= 4'd0;
      key_cols_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cols_q      <= cols_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      key_rows_q  <= key_rows_d;
      key_cols_q  <= key_cols_d;
      key_valid_q <= valid_d | rep_pulse;
      key_held_q  <= held_d;
    end
  end

  assign cols      = cols_q;
  assign key_rows  = key_rows_q;
  assign key_cols  = key_cols_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a scoreboard of expected key pulses.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_rows;
  logic [3:0] key_cols;
  logic       key_valid;
  logic       key_held;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [7:0]  exp_q[$];
  logic        prev_valid = 1'b0;

`ifdef KEYPAD_REPEAT_EN
  localparam bit RepeatEn = 1'b1;
`else
  localparam bit RepeatEn = 1'b0;
`endif

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_CYCLES  (32)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rows     (rows),
    .cols     (cols),
    .key_rows (key_rows),
    .key_cols (key_cols),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cols(input logic [3:0] c, input string tag);
    int n = 0;
    while (cols !== c && n < 40) begin
      tick(1);
      n++;
    end
    check_val(tag, 32'(cols), 32'(c));
  endtask

  task automatic wait_held(input logic h, input string tag);
    int n = 0;
    while (key_held !== h && n < 40) begin
      tick(1);
      n++;
    end
    check_val(tag, 32'(key_held), 32'(h));
  endtask

  // Scoreboard: every key_valid pulse must match the oldest expected key.
  always @(negedge clk) begin
    check_val("valid_gap", 32'(key_valid & prev_valid), 32'd0);
    prev_valid <= key_valid;
    if (key_valid === 1'b1) begin
      check_val("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check_val("key_pair", 32'({key_rows, key_cols}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int npulse;
    int first_idx;
    reset_n = 1'b0;
    rows    = 4'd0;
    tick(3);
    check_val("rst_cols", 32'(cols), 32'h1);
    check_val("rst_key_rows", 32'(key_rows), 32'h0);
    check_val("rst_key_cols", 32'(key_cols), 32'h0);
    check_val("rst_held", 32'(key_held), 32'h0);
    reset_n = 1'b1;

    // 1: idle scan rotates every 4 cycles
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] c;
      c = 4'b0001 << (k % 4);
      tick(4);
      check_val("scan_rotate", 32'(cols), 32'(c));
    end

    // 2: key in row 1 / column 2
    wait_cols(4'b0100, "reach_col2");
    exp_q.push_back({4'b0010, 4'b0100});
    rows = 4'b0010;
    wait_held(1'b1, "press_held");
    check_val("press_cols_frozen", 32'(cols), 32'h4);
    check_val("press_key_rows", 32'(key_rows), 32'h2);
    check_val("press_key_cols", 32'(key_cols), 32'h4);

    // 4: release glitch returns to HELD, full release resumes scanning
    rows = 4'b0000;
    tick(3);
    rows = 4'b0010;
    tick(4);
    check_val("glitch_held", 32'(key_held), 32'h1);
    rows = 4'b0000;
    wait_held(1'b0, "release_done");
    check_val("release_cols_adv", 32'(cols), 32'h8);
    check_val("release_key_rows_kept", 32'(key_rows), 32'h2);

    // 3: bounce during debounce is rejected
    wait_cols(4'b0100, "reach_col2_b");
    rows = 4'b0010;
    tick(7);
    rows = 4'b0000;
    tick(4);
    check_val("bounce_cols", 32'(cols), 32'h8);
    check_val("bounce_held", 32'(key_held), 32'h0);

    // 5: two rows at once are ignored; second key while held is ignored
    wait_cols(4'b0001, "reach_col0");
    rows = 4'b0011;
    tick(4);
    check_val("multi_row_rotate", 32'(cols), 32'h2);
    rows = 4'b0000;
    wait_cols(4'b0001, "reach_col0_b");
    exp_q.push_back({4'b0001, 4'b0001});
    rows = 4'b0001;
    wait_held(1'b1, "press2_held");
    rows = 4'b0101;
    tick(10);
    check_val("second_key_rows", 32'(key_rows), 32'h1);
    check_val("second_key_held", 32'(key_held), 32'h1);
    check_val("second_key_cols", 32'(cols), 32'h1);
    rows = 4'b0000;
    wait_held(1'b0, "release2_done");

    // 6: reset during debounce
    wait_cols(4'b0100, "reach_col2_c");
    rows = 4'b1000;
    tick(6);
    reset_n = 1'b0;
    #1;
    check_val("midrst_cols", 32'(cols), 32'h1);
    check_val("midrst_key_rows", 32'(key_rows), 32'h0);
    check_val("midrst_key_cols", 32'(key_cols), 32'h0);
    check_val("midrst_valid", 32'(key_valid), 32'h0);
    rows = 4'b0000;
    tick(2);
    reset_n = 1'b1;

    // Auto-repeat: hold 100 cycles after the accepted press
    exp_q.push_back({4'b0100, 4'b0001});
    if (RepeatEn) begin
      for (int i = 0; i < 3; i++) exp_q.push_back({4'b0100, 4'b0001});
    end
    rows = 4'b0100;
    wait_held(1'b1, "press3_held");
    npulse    = 0;
    first_idx = 0;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (key_valid === 1'b1) begin
        if (npulse == 0) first_idx = i;
        npulse++;
      end
    end
    check_val("repeat_count", 32'(npulse), RepeatEn ? 32'd3 : 32'd0);
    check_val("repeat_first", 32'(first_idx), RepeatEn ? 32'd32 : 32'd0);
    rows = 4'b0000;
    wait_held(1'b0, "release3_done");
    tick(5);
    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
